// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the CPU's HWInt[7:2] inputs.
// It synchronises the device request lines and latches them as edge- or
// level-mode pending bits. It masks them and drives one registered, one-hot
// request on hwint. That request is held until the CPU acknowledges by
// writing to STAT.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-low
//   irq_in  in   6   device request lines (async); bit 0 = highest priority
//   PrAddr  in   32  bridge byte address
//   PrWD    in   32  bridge write data
//   PrWe    in   1   bridge write enable
//   PrRD    out  32  combinational read data (0 outside the window)
//   hwint   out  6   one-hot request, bit k -> HWInt[k+2]
//
// Register map (offset from BASE):
//   0x0 MASK rw  [5:0]
//   0x4 PEND r   [5:0], write-1-to-clear on edge-mode bits
//   0x8 MODE rw  [5:0]  1 = edge, 0 = level
//   0xC STAT r   [31] active, [2:0] in-service index; any write = ACK
//
// state  | meaning
// IDLE   | nothing in service, hwint = 0, isr = 7
// ACTIVE | source isr in service, hwint follows its mask bit until ACK
module irq_ctrl #(
  parameter logic [31:0] BASE  = 32'h0000_7F20,
  parameter int          N_SRC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic [31:0]       PrAddr,
  input  logic [31:0]       PrWD,
  input  logic              PrWe,
  output logic [31:0]       PrRD,
  output logic [N_SRC-1:0]  hwint
);

  localparam logic [2:0]       ISR_NONE = 3'd7;
  localparam logic [N_SRC-1:0] ONE      = {{(N_SRC-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, stateNext;
  logic [2:0]       isr, isrNext, lowIdx;
  logic [N_SRC-1:0] hwintNext;
  logic [N_SRC-1:0] maskReg, pendReg, modeReg, pendNext;
  logic [N_SRC-1:0] s1, s2, prev;
  logic [N_SRC-1:0] req, isrOneHot, edgeSet, w1cClr, ackClr;
  logic             sel, wrEn, ack;
  logic [1:0]       regIdx;
  logic             unusedBits;

  assign unusedBits = ^{PrAddr[1:0], PrWD[31:N_SRC]};

  assign sel    = (PrAddr[31:4] == BASE[31:4]);
  assign regIdx = PrAddr[3:2];
  assign wrEn   = PrWe & sel;
  assign ack    = wrEn && (regIdx == 2'd3) && (state == ACTIVE);

  assign req       = pendReg & maskReg;
  assign isrOneHot = ONE << isr;

  // Lowest set index wins; scanning downward leaves the smallest one.
  always_comb begin
    lowIdx = ISR_NONE;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req[k]) lowIdx = 3'(k);
    end
  end

  // Edge-mode bits keep state and accept clears, with a same-cycle set taking
  // precedence; level-mode bits simply mirror the synchronised input.
  assign edgeSet  = s2 & ~prev;
  assign w1cClr   = (wrEn && regIdx == 2'd1) ? PrWD[N_SRC-1:0] : '0;
  assign ackClr   = ack ? isrOneHot : '0;
  assign pendNext = (modeReg & ((pendReg & ~(w1cClr | ackClr)) | edgeSet))
                  | (~modeReg & s2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      pendReg <= '0;
      maskReg <= '0;
      modeReg <= '0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      prev    <= s2;
      pendReg <= pendNext;
      if (wrEn && regIdx == 2'd0) maskReg <= PrWD[N_SRC-1:0];
      if (wrEn && regIdx == 2'd2) modeReg <= PrWD[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      isr   <= ISR_NONE;
      hwint <= '0;
    end else begin
      state <= stateNext;
      isr   <= isrNext;
      hwint <= hwintNext;
    end
  end

  always_comb begin
    stateNext = state;
    isrNext   = isr;
    hwintNext = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          stateNext = ACTIVE;
          isrNext   = lowIdx;
          hwintNext = ONE << lowIdx;
        end
      end
      ACTIVE: begin
        if (ack) begin
          stateNext = IDLE;
          isrNext   = ISR_NONE;
        end else begin
          // Masking the in-service source silences hwint but keeps it in service.
          hwintNext = isrOneHot & maskReg;
        end
      end
      default: begin
        stateNext = IDLE;
        isrNext   = ISR_NONE;
      end
    endcase
  end

  always_comb begin
    PrRD = '0;
    if (sel) begin
      case (regIdx)
        2'd0: PrRD[N_SRC-1:0] = maskReg;
        2'd1: PrRD[N_SRC-1:0] = pendReg;
        2'd2: PrRD[N_SRC-1:0] = modeReg;
        default: begin
          PrRD[31]  = (state == ACTIVE);
          PrRD[2:0] = isr;
        end
      endcase
    end
  end

endmodule
